// File: rtl/axil_axis_tx_fifo_pkg.sv
// Shared constants and types for the AXI4-Lite to AXI4-Stream TX FIFO.
// Register offsets are word indices taken from address bits [5:2].
package axil_axis_tx_pkg;

  localparam logic [3:0] ADDR_ISR  = 4'h0;
  localparam logic [3:0] ADDR_IER  = 4'h1;
  localparam logic [3:0] ADDR_TDFR = 4'h2;
  localparam logic [3:0] ADDR_TDFV = 4'h3;
  localparam logic [3:0] ADDR_TDFD = 4'h4;
  localparam logic [3:0] ADDR_TLR  = 4'h5;

  localparam int unsigned ISR_TC     = 0;
  localparam int unsigned ISR_TXOVR  = 1;
  localparam int unsigned ISR_LENERR = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [31:0] TDFR_KEY = 32'h0000_00A5;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  // Byte length to word count, computed in 33 bits so 32'hFFFF_FFFF cannot wrap to zero.
  function automatic logic [32:0] tlr_words(input logic [31:0] len);
    logic [32:0] sum;
    sum = {1'b0, len} + 33'd3;
    return sum >> 2;
  endfunction

endpackage

// File: rtl/axil_axis_tx_fifo_if.sv
// AXI4-Lite responder port plus outbound AXI4-Stream port of the TX FIFO.
// slave is the design's view, master is the initiator/sink view.
interface axil_axis_tx_fifo_if;
  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;
  logic [31:0] AXI_STR_TXD_tdata;
  logic        AXI_STR_TXD_tlast;
  logic        AXI_STR_TXD_tvalid;
  logic        AXI_STR_TXD_tready;

  modport slave (
    input  axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    input  axi_araddr, axi_arprot, axi_arvalid, axi_rready, AXI_STR_TXD_tready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp,
    output axi_rvalid, AXI_STR_TXD_tdata, AXI_STR_TXD_tlast, AXI_STR_TXD_tvalid
  );

  modport master (
    output axi_awaddr, axi_awprot, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid, axi_bready,
    output axi_araddr, axi_arprot, axi_arvalid, axi_rready, AXI_STR_TXD_tready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid, axi_arready, axi_rdata, axi_rresp,
    input  axi_rvalid, AXI_STR_TXD_tdata, AXI_STR_TXD_tlast, AXI_STR_TXD_tvalid
  );
endinterface

// File: rtl/axil_axis_tx_fifo_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; head is the oldest stored word.
// Pushes while full and pops while empty are ignored; flush empties in one cycle.
module sync_fifo #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned WIDTH = 32,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage has no reset; occupancy tracking alone defines valid contents.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/axil_axis_tx_fifo.sv
// AXI4-Lite register front end feeding a TX FIFO that is drained as
// length-delimited AXI4-Stream packets.
module axil_axis_tx_fifo
  import axil_axis_tx_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 512
) (
  input  logic               aclk,
  input  logic               areset,
  axil_axis_tx_fifo_if.slave bus,
  output logic               interrupt,
  output logic               mm2s_prmry_reset_out_n
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [31:0]   rdata_q;
  logic [2:0]    isr_q, isr_d, ier_q;
  logic          irq_q, rst_out_n_q;
  tx_state_t     state_q, state_d;
  logic [CW-1:0] remaining_q, remaining_d;

  logic          fifo_push, fifo_flush, fifo_full, fifo_empty, tx_beat;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;
  logic          wr_ok, ier_wr, tlr_wr, tlr_ok, tc_set;
  logic [2:0]    isr_w1c, isr_set;
  logic [32:0]   tlr_len_words;
  logic [31:0]   rd_data;
  logic [1:0]    rd_resp;
  logic [3:0]    wr_sel, rd_sel;
  logic          unused_inputs;

  assign wr_sel        = bus.axi_awaddr[5:2];
  assign rd_sel        = bus.axi_araddr[5:2];
  assign tlr_len_words = tlr_words(bus.axi_wdata);
  assign tx_beat       = (state_q == TX_SEND) && bus.AXI_STR_TXD_tready;
  assign unused_inputs = ^{bus.axi_awprot, bus.axi_wstrb, bus.axi_arprot, bus.axi_awaddr[31:6],
                           bus.axi_awaddr[1:0], bus.axi_araddr[31:6], bus.axi_araddr[1:0],
                           fifo_empty};

  sync_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (aclk),
    .rst  (areset),
    .push (fifo_push),
    .wdata(bus.axi_wdata),
    .pop  (tx_beat),
    .flush(fifo_flush),
    .head (fifo_head),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  // Register side effects happen only in the single awready/wready cycle.
  always_comb begin
    wr_ok      = 1'b0;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    ier_wr     = 1'b0;
    tlr_wr     = 1'b0;
    isr_w1c    = '0;
    if (awready_q) begin
      wr_ok = 1'b1;
      case (wr_sel)
        ADDR_ISR:  isr_w1c    = bus.axi_wdata[2:0];
        ADDR_IER:  ier_wr     = 1'b1;
        ADDR_TDFR: fifo_flush = (bus.axi_wdata == TDFR_KEY);
        ADDR_TDFD: fifo_push  = 1'b1;
        ADDR_TLR:  tlr_wr     = 1'b1;
        default:   wr_ok      = 1'b0;
      endcase
    end
  end

  assign tlr_ok = tlr_wr && (state_q == TX_IDLE) && (tlr_len_words != '0) &&
                  (tlr_len_words <= 33'(fifo_count));

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    tc_set      = 1'b0;
    if (fifo_flush) begin
      state_d     = TX_IDLE;
      remaining_d = '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (tlr_ok) begin
            state_d     = TX_SEND;
            remaining_d = tlr_len_words[CW-1:0];
          end
        end
        TX_SEND: begin
          if (tx_beat) begin
            remaining_d = remaining_q - 1'b1;
            if (remaining_q == CW'(1)) begin
              state_d = TX_IDLE;
              tc_set  = 1'b1;
            end
          end
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  // Hardware sets are OR-ed after the W1C mask so a coincident set survives.
  always_comb begin
    isr_set             = '0;
    isr_set[ISR_TC]     = tc_set;
    isr_set[ISR_TXOVR]  = fifo_push && fifo_full;
    isr_set[ISR_LENERR] = tlr_wr && !tlr_ok;
    isr_d               = (isr_q & ~isr_w1c) | isr_set;
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      ADDR_ISR:  rd_data = {29'd0, isr_q};
      ADDR_IER:  rd_data = {29'd0, ier_q};
      ADDR_TDFV: rd_data = 32'(FIFO_DEPTH) - 32'(fifo_count);
      default:   rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= RESP_OKAY;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
      isr_q       <= '0;
      ier_q       <= '0;
      irq_q       <= 1'b0;
      rst_out_n_q <= 1'b1;
      state_q     <= TX_IDLE;
      remaining_q <= '0;
    end else begin
      awready_q <= bus.axi_awvalid && bus.axi_wvalid && !bvalid_q && !awready_q;
      if (awready_q) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_q && bus.axi_bready) begin
        bvalid_q <= 1'b0;
      end
      arready_q <= bus.axi_arvalid && !rvalid_q && !arready_q;
      if (arready_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data;
        rresp_q  <= rd_resp;
      end else if (rvalid_q && bus.axi_rready) begin
        rvalid_q <= 1'b0;
      end
      if (ier_wr) ier_q <= bus.axi_wdata[2:0];
      isr_q       <= isr_d;
      irq_q       <= |(isr_q & ier_q);
      rst_out_n_q <= !fifo_flush;
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  assign bus.axi_awready        = awready_q;
  assign bus.axi_wready         = awready_q;
  assign bus.axi_bvalid         = bvalid_q;
  assign bus.axi_bresp          = bresp_q;
  assign bus.axi_arready        = arready_q;
  assign bus.axi_rvalid         = rvalid_q;
  assign bus.axi_rdata          = rdata_q;
  assign bus.axi_rresp          = rresp_q;
  assign bus.AXI_STR_TXD_tvalid = (state_q == TX_SEND);
  assign bus.AXI_STR_TXD_tdata  = (state_q == TX_SEND) ? fifo_head : '0;
  assign bus.AXI_STR_TXD_tlast  = (state_q == TX_SEND) && (remaining_q == CW'(1));
  assign interrupt              = irq_q;
  assign mm2s_prmry_reset_out_n = rst_out_n_q;

endmodule

// File: tb/tb_axil_axis_tx_fifo.sv
// Self-checking bench: register vector table, a stream scoreboard queue and
// hand-written packet, overflow, length-error, stall and flush sequences.
module tb_axil_axis_tx_fifo;
  import axil_axis_tx_pkg::*;

  localparam int unsigned Depth = 512;

  logic aclk = 1'b0;
  logic areset;
  logic interrupt;
  logic rst_out_n;

  always #5 aclk = ~aclk;

  axil_axis_tx_fifo_if bus ();

  axil_axis_tx_fifo #(
    .FIFO_DEPTH(Depth)
  ) dut (
    .aclk                  (aclk),
    .areset                (areset),
    .bus                   (bus),
    .interrupt             (interrupt),
    .mm2s_prmry_reset_out_n(rst_out_n)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  beat_t exp_q[$];
  vec_t  vecs[14];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int aw_cyc = 0;
  int beat_cnt = 0;
  int last_beat_cyc = 0;
  int tv_rise_cyc = 0;
  int rst_low_cnt = 0;
  logic        tv_prev = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic        stall_last = 1'b0;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Stream monitor and scoreboard, sampled mid-cycle away from the active edge.
  always @(negedge aclk) begin
    beat_t b;
    if (!areset) begin
      if (bus.AXI_STR_TXD_tvalid && !tv_prev) tv_rise_cyc = cyc;
      if (stall_prev && bus.AXI_STR_TXD_tvalid) begin
        check("stall_tdata", bus.AXI_STR_TXD_tdata, stall_data);
        check("stall_tlast", 32'(bus.AXI_STR_TXD_tlast), 32'(stall_last));
      end
      if (bus.AXI_STR_TXD_tvalid && bus.AXI_STR_TXD_tready) begin
        beat_cnt++;
        last_beat_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got tdata 0x%0h, expected no beat",
                   bus.AXI_STR_TXD_tdata);
        end else begin
          b = exp_q.pop_front();
          check("tdata", bus.AXI_STR_TXD_tdata, b.data);
          check("tlast", 32'(bus.AXI_STR_TXD_tlast), 32'(b.last));
        end
      end
      stall_prev = bus.AXI_STR_TXD_tvalid && !bus.AXI_STR_TXD_tready;
      stall_data = bus.AXI_STR_TXD_tdata;
      stall_last = bus.AXI_STR_TXD_tlast;
      tv_prev    = bus.AXI_STR_TXD_tvalid;
      if (!rst_out_n) begin
        rst_low_cnt++;
        check("tvalid_during_flush_pulse", 32'(bus.AXI_STR_TXD_tvalid), 32'd0);
      end
    end
  end

  task automatic axil_write(input logic [31:0] addr, input logic [31:0] data,
                            output logic [1:0] resp);
    int n;
    @(posedge aclk); #1;
    bus.axi_awaddr  = addr;
    bus.axi_wdata   = data;
    bus.axi_awvalid = 1'b1;
    bus.axi_wvalid  = 1'b1;
    n = 0;
    while (!bus.axi_awready && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!bus.axi_awready) timeout_fail("awready");
    aw_cyc = cyc;
    @(posedge aclk); #1;
    bus.axi_awvalid = 1'b0;
    bus.axi_wvalid  = 1'b0;
    n = 0;
    while (!bus.axi_bvalid && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!bus.axi_bvalid) timeout_fail("bvalid");
    resp = bus.axi_bresp;
    @(posedge aclk); #1;
  endtask

  task automatic axil_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
    int n;
    @(posedge aclk); #1;
    bus.axi_araddr  = addr;
    bus.axi_arvalid = 1'b1;
    n = 0;
    while (!bus.axi_arready && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!bus.axi_arready) timeout_fail("arready");
    @(posedge aclk); #1;
    bus.axi_arvalid = 1'b0;
    n = 0;
    while (!bus.axi_rvalid && n < 50) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!bus.axi_rvalid) timeout_fail("rvalid");
    data = bus.axi_rdata;
    resp = bus.axi_rresp;
    @(posedge aclk); #1;
  endtask

  task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] r;
    axil_write(addr, data, r);
    check("bresp_okay", 32'(r), 32'(RESP_OKAY));
  endtask

  task automatic rd_expect(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0]  r;
    axil_read(addr, d, r);
    check({name, "_rresp"}, 32'(r), 32'(RESP_OKAY));
    check(name, d, exp);
  endtask

  task automatic push_word(input logic [31:0] data, input logic last, input logic expect_tx);
    wr_ok(32'h10, data);
    if (expect_tx) exp_q.push_back('{data: data, last: last});
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge aclk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      timeout_fail("stream_drain");
      exp_q.delete();
    end
    repeat (3) @(posedge aclk);
    #1;
  endtask

  task automatic wait_tvalid();
    int n;
    n = 0;
    while (!bus.AXI_STR_TXD_tvalid && n < 20) begin
      @(posedge aclk); #1;
      n++;
    end
    if (!bus.AXI_STR_TXD_tvalid) timeout_fail("tvalid_start");
  endtask

  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    logic        pat [6];
    int          b0;

    vecs[0]  = '{1'b0, 32'h0000_000C, 32'h0, RESP_OKAY,   32'd512};
    vecs[1]  = '{1'b0, 32'h0000_0000, 32'h0, RESP_OKAY,   32'd0};
    vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0, RESP_OKAY,   32'd0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0, RESP_SLVERR, 32'd0};
    vecs[4]  = '{1'b0, 32'h0000_0008, 32'h0, RESP_SLVERR, 32'd0};
    vecs[5]  = '{1'b0, 32'h0000_0014, 32'h0, RESP_SLVERR, 32'd0};
    vecs[6]  = '{1'b0, 32'h0000_0018, 32'h0, RESP_SLVERR, 32'd0};
    vecs[7]  = '{1'b1, 32'h0000_000C, 32'h5, RESP_SLVERR, 32'd0};
    vecs[8]  = '{1'b1, 32'h0000_003C, 32'h5, RESP_SLVERR, 32'd0};
    vecs[9]  = '{1'b1, 32'h0000_0004, 32'h7, RESP_OKAY,   32'd0};
    vecs[10] = '{1'b0, 32'hFFFF_FF44, 32'h0, RESP_OKAY,   32'd7};
    vecs[11] = '{1'b1, 32'h0000_0004, 32'h0, RESP_OKAY,   32'd0};
    vecs[12] = '{1'b1, 32'h0000_0008, 32'h12, RESP_OKAY,  32'd0};
    vecs[13] = '{1'b0, 32'h1234_5640, 32'h0, RESP_OKAY,   32'd0};
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    areset                 = 1'b1;
    bus.axi_awaddr         = '0;
    bus.axi_awprot         = '0;
    bus.axi_awvalid        = 1'b0;
    bus.axi_wdata          = '0;
    bus.axi_wstrb          = 4'hF;
    bus.axi_wvalid         = 1'b0;
    bus.axi_bready         = 1'b1;
    bus.axi_araddr         = '0;
    bus.axi_arprot         = '0;
    bus.axi_arvalid        = 1'b0;
    bus.axi_rready         = 1'b1;
    bus.AXI_STR_TXD_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_awready", 32'(bus.axi_awready), 32'd0);
    check("rst_wready", 32'(bus.axi_wready), 32'd0);
    check("rst_bvalid", 32'(bus.axi_bvalid), 32'd0);
    check("rst_bresp", 32'(bus.axi_bresp), 32'd0);
    check("rst_arready", 32'(bus.axi_arready), 32'd0);
    check("rst_rvalid", 32'(bus.axi_rvalid), 32'd0);
    check("rst_rresp", 32'(bus.axi_rresp), 32'd0);
    check("rst_rdata", bus.axi_rdata, 32'd0);
    check("rst_tvalid", 32'(bus.AXI_STR_TXD_tvalid), 32'd0);
    check("rst_tdata", bus.AXI_STR_TXD_tdata, 32'd0);
    check("rst_tlast", 32'(bus.AXI_STR_TXD_tlast), 32'd0);
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_reset_out_n", 32'(rst_out_n), 32'd1);
    areset = 1'b0;
    repeat (2) @(posedge aclk);
    #1;

    // Register access table.
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        axil_write(vecs[i].addr, vecs[i].data, r);
        check($sformatf("vec%0d_bresp", i), 32'(r), 32'(vecs[i].resp));
      end else begin
        axil_read(vecs[i].addr, d, r);
        check($sformatf("vec%0d_rresp", i), 32'(r), 32'(vecs[i].resp));
        check($sformatf("vec%0d_rdata", i), d, vecs[i].rdata);
      end
    end
    check("non_key_tdfr_no_pulse", 32'(rst_low_cnt), 32'd0);
    check("interrupt_after_table", 32'(interrupt), 32'd0);

    // Basic 3-word packet with interrupt.
    push_word(32'h11, 1'b0, 1'b1);
    push_word(32'h22, 1'b0, 1'b1);
    push_word(32'h33, 1'b1, 1'b1);
    rd_expect("tdfv_three", 32'h0C, 32'd509);
    wr_ok(32'h04, 32'h1);
    b0 = beat_cnt;
    wr_ok(32'h14, 32'd12);
    wait_drain();
    check("pkt1_beats", 32'(beat_cnt - b0), 32'd3);
    check("pkt1_first_tvalid_latency", 32'(tv_rise_cyc), 32'(aw_cyc + 1));
    check("pkt1_no_bubble", 32'(last_beat_cyc - tv_rise_cyc), 32'd2);
    rd_expect("pkt1_isr", 32'h00, 32'h1);
    check("pkt1_interrupt", 32'(interrupt), 32'd1);
    rd_expect("pkt1_tdfv", 32'h0C, 32'd512);
    wr_ok(32'h00, 32'h1);
    repeat (2) @(posedge aclk);
    #1;
    check("interrupt_cleared", 32'(interrupt), 32'd0);

    // Fill to full, overflow word is dropped, then drain the full FIFO.
    for (int i = 0; i < Depth; i++) begin
      push_word(32'h1000 + 32'(i), (i == Depth - 1), 1'b1);
    end
    push_word(32'hDEAD, 1'b0, 1'b0);
    rd_expect("full_tdfv", 32'h0C, 32'd0);
    rd_expect("txovr_isr", 32'h00, 32'h2);
    wr_ok(32'h00, 32'h2);
    rd_expect("txovr_cleared", 32'h00, 32'h0);
    b0 = beat_cnt;
    wr_ok(32'h14, 32'd2048);
    wait_drain();
    check("full_pkt_beats", 32'(beat_cnt - b0), 32'd512);
    rd_expect("full_pkt_isr", 32'h00, 32'h1);
    rd_expect("full_pkt_tdfv", 32'h0C, 32'd512);
    wr_ok(32'h00, 32'h7);

    // Length errors: too long, zero, and 33-bit overflow; then a ceil(5/4) packet.
    push_word(32'hA, 1'b0, 1'b0);
    push_word(32'hB, 1'b0, 1'b0);
    wr_ok(32'h14, 32'd9);
    check("lenerr_long_tvalid", 32'(bus.AXI_STR_TXD_tvalid), 32'd0);
    rd_expect("lenerr_long_isr", 32'h00, 32'h4);
    wr_ok(32'h00, 32'h4);
    wr_ok(32'h14, 32'd0);
    check("lenerr_zero_tvalid", 32'(bus.AXI_STR_TXD_tvalid), 32'd0);
    rd_expect("lenerr_zero_isr", 32'h00, 32'h4);
    wr_ok(32'h00, 32'h4);
    wr_ok(32'h14, 32'hFFFF_FFFF);
    rd_expect("lenerr_max_isr", 32'h00, 32'h4);
    wr_ok(32'h00, 32'h4);
    rd_expect("lenerr_tdfv", 32'h0C, 32'd510);
    exp_q.push_back('{data: 32'hA, last: 1'b0});
    exp_q.push_back('{data: 32'hB, last: 1'b1});
    wr_ok(32'h14, 32'd5);
    wait_drain();
    rd_expect("ceil_pkt_isr", 32'h00, 32'h1);
    wr_ok(32'h00, 32'h1);

    // Stalled 4-word packet with tready pattern 1 0 0 1 1 1.
    bus.AXI_STR_TXD_tready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h401 + 32'(i), (i == 3), 1'b1);
    b0 = beat_cnt;
    wr_ok(32'h14, 32'd16);
    wait_tvalid();
    for (int i = 0; i < 6; i++) begin
      bus.AXI_STR_TXD_tready = pat[i];
      @(posedge aclk); #1;
    end
    bus.AXI_STR_TXD_tready = 1'b1;
    wait_drain();
    check("stall_pkt_beats", 32'(beat_cnt - b0), 32'd4);
    rd_expect("stall_pkt_isr", 32'h00, 32'h1);
    wr_ok(32'h00, 32'h1);

    // Flush in the middle of a packet.
    bus.AXI_STR_TXD_tready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h501 + 32'(i), 1'b0, 1'b0);
    exp_q.push_back('{data: 32'h501, last: 1'b0});
    wr_ok(32'h14, 32'd16);
    wait_tvalid();
    bus.AXI_STR_TXD_tready = 1'b1;
    @(posedge aclk); #1;
    bus.AXI_STR_TXD_tready = 1'b0;
    check("mid_packet_tvalid", 32'(bus.AXI_STR_TXD_tvalid), 32'd1);
    check("mid_packet_first_beat_seen", 32'(exp_q.size()), 32'd0);
    rst_low_cnt = 0;
    wr_ok(32'h08, TDFR_KEY);
    repeat (3) @(posedge aclk);
    #1;
    check("flush_pulse_cycles", 32'(rst_low_cnt), 32'd1);
    check("flush_reset_out_n_high", 32'(rst_out_n), 32'd1);
    check("flush_tvalid", 32'(bus.AXI_STR_TXD_tvalid), 32'd0);
    bus.AXI_STR_TXD_tready = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    rd_expect("flush_tdfv", 32'h0C, 32'd512);
    rd_expect("flush_isr", 32'h00, 32'h0);

    // Error responses.
    axil_read(32'h10, d, r);
    check("rd_tdfd_rresp", 32'(r), 32'(RESP_SLVERR));
    check("rd_tdfd_rdata", d, 32'd0);
    axil_write(32'h0C, 32'h1, r);
    check("wr_tdfv_bresp", 32'(r), 32'(RESP_SLVERR));
    rd_expect("wr_tdfv_no_effect", 32'h0C, 32'd512);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/axil_axis_tx_fifo.md
# axil_axis_tx_fifo

AXI4-Lite responder that buffers 32-bit words written by an AXI4-Lite initiator and transmits them as length-delimited AXI4-Stream packets. It is the register/stream end of the AXI-Lite link whose initiator side is driven by the app_* command interface. Its register map is a TX-only subset of a stream-FIFO core: interrupt status/enable, FIFO reset, vacancy, data and length registers.

## Interface
- FIFO_DEPTH, 512: TX FIFO depth in 32-bit words; power of two, minimum 4.
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- axi_awaddr/awprot/awvalid/awready  in,in,in,out  32,3,1,1  write address; awprot ignored.
- axi_wdata/wstrb/wvalid/wready  in,in,in,out  32,4,1,1  write data; wstrb ignored, full-word writes only.
- axi_bresp/bvalid/bready  out,out,in  2,1,1  write response.
- axi_araddr/arprot/arvalid/arready  in,in,in,out  32,3,1,1  read address; arprot ignored.
- axi_rdata/rresp/rvalid/rready  out,out,out,in  32,2,1,1  read data.
- AXI_STR_TXD_tdata/tlast/tvalid/tready  out,out,out,in  32,1,1,1  outbound stream.
- interrupt  out  1  registered OR of (ISR & IER).
- mm2s_prmry_reset_out_n  out  1  low for exactly 1 cycle after a FIFO reset command.

## Operation
- Register decode on awaddr/araddr[5:2]. Upper bits are ignored.
  - 0x00 ISR, RW1C: bit0 TC (packet complete), bit1 TXOVR (write to full FIFO), bit2 LENERR.
  - 0x04 IER, RW: bits[2:0].
  - 0x08 TDFR, WO: writing 0x0000_00A5 flushes the FIFO, aborts any transmission and pulses mm2s_prmry_reset_out_n. Any other value is ignored with OKAY.
  - 0x0C TDFV, RO: vacancy, FIFO_DEPTH minus occupancy, zero-extended.
  - 0x10 TDFD, WO: pushes wdata. If the FIFO is full, the word is dropped and TXOVR is set.
  - 0x14 TLR, WO: value L is a length in bytes; words = ceil(L/4) using L[31:0]+3 >> 2 in 33 bits. Transmission starts if the TX engine is idle and 0 < words <= occupancy. Otherwise LENERR is set and there is no transmission.
- Reads of WO registers or unmapped offsets, and writes to RO or unmapped offsets, return bresp/rresp = SLVERR (2'b10) with rdata = 0 and no side effect. All other accesses return OKAY (2'b00).
- TX engine states:
  - TX_IDLE goes to TX_SEND on an accepted TLR write; the remaining-word counter is loaded with words.
  - In TX_SEND: tvalid = 1, tdata = FIFO head, tlast = (remaining == 1).
  - Each tvalid & tready beat pops the FIFO and decrements remaining.
  - On the last beat, set TC and return to TX_IDLE.
- TDFD pushes are allowed during TX_SEND. The same-cycle push and pop leave occupancy unchanged.
- A TDFR flush during TX_SEND forces TX_IDLE and drops tvalid the next cycle. This deliberately violates AXIS stability, as a reset.
- A simultaneous W1C to ISR and a hardware set of the same bit: the set wins.

## Timing
- Reset values: all ready/valid outputs 0, bresp/rresp 0, rdata 0, tdata 0, tlast 0, ISR/IER 0, FIFO empty (TDFV = FIFO_DEPTH), interrupt 0, mm2s_prmry_reset_out_n 1.
- Write handshake:
  - Cycle N: awvalid & wvalid & !bvalid & !awready.
  - Cycle N+1: awready = wready = 1 for exactly 1 cycle; the register effect is visible at N+2.
  - Cycle N+2: bvalid = 1, held until bready. No new write is accepted while bvalid = 1.
- Read handshake:
  - Cycle N: arvalid & !rvalid & !arready.
  - Cycle N+1: arready = 1 for 1 cycle.
  - Cycle N+2: rvalid with rdata/rresp, held stable until rready.
- Read and write paths are independent and may complete in the same cycle. A TDFV read sampled in the same cycle as a push returns the pre-push value.
- First tvalid appears 1 cycle after the TLR write's awready/wready cycle. tdata is from the registered FIFO head with no bubble between beats when tready stays high.
- interrupt lags its ISR/IER cause by 1 cycle.

## Structure
- Package axil_axis_tx_pkg holds:
  - register offset constants: ISR, IER, TDFR, TDFD, TDFV, TLR;
  - ISR bit indices;
  - RESP_OKAY and RESP_SLVERR;
  - the TDFR key 32'hA5;
  - the tx_state_t enum {TX_IDLE, TX_SEND}.
- One sub-module, sync_fifo: a single-clock FIFO with parameters DEPTH and WIDTH. It has push, pop, flush, full, empty, count and a first-word-fall-through head output.

## Test plan
- Reset, then read 0x0C → rdata = 512, rresp OKAY. Read 0x00 → 0. interrupt = 0.
- Write 0x11, 0x22, 0x33 to 0x10, write IER = 1, then TLR = 12 with tready = 1 → exactly 3 beats 0x11, 0x22, 0x33, tlast on the 3rd only. ISR = 1, interrupt = 1. TDFV returns 512.
- Fill with 512 writes, then a 513th write of 0xDEAD → TDFV = 0, ISR bit1 = 1, and that word is never transmitted. Write ISR = 2 → bit1 clears.
- Two words in the FIFO, TLR = 9 (3 words) → LENERR set, tvalid stays 0. TLR = 0 → LENERR set, tvalid stays 0.
- Four words, TLR = 16, tready toggled 1 0 0 1 1 1 → tdata/tlast held stable while stalled. Beats occur in order, and tlast is on the 4th.
- Mid-packet, write 0xA5 to 0x08 → mm2s_prmry_reset_out_n low 1 cycle, tvalid = 0 the next cycle, TDFV = 512.
- Read 0x10 → SLVERR, rdata = 0. Write 0x0C → SLVERR.
